// File: rtl/arith_pkg.sv
// Shared definitions for the iterative divider: FSM states, default operand
// width and the counter-width helper.
package arith_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_e;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/divider_unit_if.sv
// Request/result bundle between the ALU sequencer (master) and the divider (slave).
interface divider_unit_if
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, in1, in2,
    input  out, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, in1, in2,
    output out, remainder, busy, done, div_by_zero
  );

endinterface

// File: rtl/divider_sub_stage.sv
// Combinational N-bit ripple full-adder subtractor: a + ~b + 1, borrow = ~carry_out.
// The difference drops its top bit: callers only keep it when no borrow occurred
// and the result is known to be below 2^(N-1).
module divider_sub_stage #(
  parameter int N = 5
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-2:0] o_diff,
  output logic         o_borrow
);

  logic [N:0]   w_carry;
  logic [N-1:0] w_b_n;

  assign w_carry[0] = 1'b1;
  assign w_b_n      = ~i_b;

  for (genvar g = 0; g < N; g++) begin : g_carry
    assign w_carry[g+1] = (i_a[g] & w_b_n[g]) | (w_carry[g] & (i_a[g] ^ w_b_n[g]));
  end

  for (genvar g = 0; g < N - 1; g++) begin : g_sum
    assign o_diff[g] = i_a[g] ^ w_b_n[g] ^ w_carry[g];
  end

  assign o_borrow = ~w_carry[N];

endmodule

// File: rtl/divider_unit.sv
// Iterative restoring unsigned divider, one quotient bit per clock.
// Optional macro DIVIDER_FAST_PATH_EN: finish in 2 cycles when in1 <= in2.
module divider_unit
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  divider_unit_if.slave  bus
);

  localparam int CW = clog2(WIDTH + 1);

  state_e           r_state;
  state_e           w_next;
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_prem;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_rem;
  logic [CW-1:0]    r_count;
  logic             r_done;
  logic             r_dbz;

  logic             w_zero;
  logic             w_fast;
  logic [WIDTH-1:0] w_fast_q;
  logic [WIDTH-1:0] w_fast_r;
  logic [WIDTH:0]   w_shifted;
  logic [WIDTH-1:0] w_diff;
  logic             w_borrow;

  assign w_zero = ~|bus.in2;

`ifdef DIVIDER_FAST_PATH_EN
  logic w_eq;
  assign w_eq     = ~|(bus.in1 ^ bus.in2);
  assign w_fast   = w_eq | (bus.in1 < bus.in2);
  assign w_fast_q = {{(WIDTH-1){1'b0}}, w_eq};
  assign w_fast_r = w_eq ? '0 : bus.in1;
`else
  assign w_fast   = 1'b0;
  assign w_fast_q = '0;
  assign w_fast_r = '0;
`endif

  // Next partial remainder candidate: old remainder with the next dividend MSB appended.
  assign w_shifted = {r_prem, r_dividend[WIDTH-1]};

  divider_sub_stage #(
    .N (WIDTH + 1)
  ) u_sub (
    .i_a      (w_shifted),
    .i_b      ({1'b0, r_divisor}),
    .o_diff   (w_diff),
    .o_borrow (w_borrow)
  );

  // NOTE: registers take non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // NOTE: w_next gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = (w_zero || w_fast) ? FINISH : RUN;
      RUN:     if (r_count == CW'(1)) w_next = FINISH;
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dividend <= '0;
      r_divisor  <= '0;
      r_prem     <= '0;
      r_quot     <= '0;
      r_out      <= '0;
      r_rem      <= '0;
      r_count    <= '0;
      r_done     <= 1'b0;
      r_dbz      <= 1'b0;
    end else begin
      r_done <= (r_state == FINISH);
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_dividend <= bus.in1;
            r_divisor  <= bus.in2;
            r_count    <= CW'(WIDTH);
            r_dbz      <= w_zero;
            if (w_zero) begin
              r_quot <= '1;
              r_prem <= bus.in1;
            end else if (w_fast) begin
              r_quot <= w_fast_q;
              r_prem <= w_fast_r;
            end else begin
              r_quot <= '0;
              r_prem <= '0;
            end
          end
        end
        RUN: begin
          // Restore on borrow by keeping the shifted value instead of the difference.
          r_prem     <= w_borrow ? w_shifted[WIDTH-1:0] : w_diff;
          r_quot     <= {r_quot[WIDTH-2:0], ~w_borrow};
          r_dividend <= r_dividend << 1;
          r_count    <= r_count - CW'(1);
        end
        FINISH: begin
          r_out <= r_quot;
          r_rem <= r_prem;
        end
        default: ;
      endcase
    end
  end

  assign bus.out         = r_out;
  assign bus.remainder   = r_rem;
  assign bus.busy        = (r_state != IDLE);
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_divider_unit.sv
// Self-checking bench for divider_unit (WIDTH=4): directed cases, full sweep plus
// random operands against a floor-division model, reset abort and busy handshake.
module tb_divider_unit;

  localparam int W        = 4;
  localparam int LAT_FULL = W + 2;
  localparam int MAXV     = (1 << W) - 1;
`ifdef DIVIDER_FAST_PATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  divider_unit_if #(.WIDTH(W)) bus ();

  divider_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  function automatic int exp_latency(input int a, input int b);
    if (b == 0) return 2;
    if (FAST && a <= b) return 2;
    return LAT_FULL;
  endfunction

  // Issues one division starting now (just after a rising edge, DUT idle) and
  // returns when done is seen or the cycle budget runs out.
  task automatic do_div(input int a, input int b,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic z, output logic busy_at_done,
                        output logic done_stale, output int lat);
    bit seen;
    bus.start    = 1'b1;
    bus.in1      = W'(a);
    bus.in2      = W'(b);
    lat          = 0;
    seen         = 1'b0;
    q            = '0;
    r            = '0;
    z            = 1'b0;
    busy_at_done = 1'b1;
    done_stale   = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        bus.start  = 1'b0;
        bus.in1    = W'($urandom);
        bus.in2    = W'($urandom);
        done_stale = bus.done;
      end else if (bus.done) begin
        seen         = 1'b1;
        q            = bus.out;
        r            = bus.remainder;
        z            = bus.div_by_zero;
        busy_at_done = bus.busy;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus.out, bus.remainder, bus.busy, bus.done, bus.div_by_zero} !== '0) begin
      bad++;
      $display("FAIL reset_hold outputs got=%h want=0",
               {bus.out, bus.remainder, bus.busy, bus.done, bus.div_by_zero});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({bus.out, bus.remainder, bus.busy, bus.done, bus.div_by_zero} !== '0) begin
      bad++;
      $display("FAIL reset_release outputs got=%h want=0",
               {bus.out, bus.remainder, bus.busy, bus.done, bus.div_by_zero});
    end
  endtask

  task automatic test_directed;
    int ta[5] = '{13, 15, 2, 7, 9};
    int tb[5] = '{ 3,  1, 5, 0, 2};
    int tq[5] = '{ 4, 15, 0, 15, 4};
    int tr[5] = '{ 1,  0, 2, 7, 1};
    int tz[5] = '{ 0,  0, 0, 1, 0};
    logic [W-1:0] q, r;
    logic z, bz, st;
    int lat;
    for (int i = 0; i < 5; i++) begin
      do_div(ta[i], tb[i], q, r, z, bz, st, lat);
      total++;
      if (q !== W'(tq[i]) || r !== W'(tr[i])) begin
        bad++;
        $display("FAIL directed_result %0d/%0d got q=%0d r=%0d want q=%0d r=%0d",
                 ta[i], tb[i], q, r, tq[i], tr[i]);
      end
      total++;
      if (z !== tz[i][0]) begin
        bad++;
        $display("FAIL directed_dbz %0d/%0d got=%0b want=%0b", ta[i], tb[i], z, tz[i][0]);
      end
      total++;
      if (lat != exp_latency(ta[i], tb[i])) begin
        bad++;
        $display("FAIL directed_latency %0d/%0d got=%0d want=%0d",
                 ta[i], tb[i], lat, exp_latency(ta[i], tb[i]));
      end
    end
  endtask

  task automatic test_sweep_random;
    logic [W-1:0] q, r;
    logic z, bz, st;
    int lat;
    int n_full;
    n_full = (MAXV + 1) * (MAXV + 1);
    for (int i = 0; i < n_full + 200; i++) begin
      int a, b, eq, er;
      if (i < n_full) begin
        a = i / (MAXV + 1);
        b = i % (MAXV + 1);
      end else begin
        a = $urandom_range(MAXV);
        b = $urandom_range(MAXV);
      end
      eq = (b == 0) ? MAXV : a / b;
      er = (b == 0) ? a : a % b;
      do_div(a, b, q, r, z, bz, st, lat);
      total++;
      if (q !== W'(eq) || r !== W'(er)) begin
        bad++;
        $display("FAIL sweep_result %0d/%0d got q=%0d r=%0d want q=%0d r=%0d", a, b, q, r, eq, er);
      end
      total++;
      if (z !== (b == 0)) begin
        bad++;
        $display("FAIL sweep_dbz %0d/%0d got=%0b want=%0b", a, b, z, (b == 0));
      end
      total++;
      if (lat != exp_latency(a, b)) begin
        bad++;
        $display("FAIL sweep_latency %0d/%0d got=%0d want=%0d", a, b, lat, exp_latency(a, b));
      end
      total++;
      if (bz !== 1'b0 || st !== 1'b0) begin
        bad++;
        $display("FAIL sweep_pulse %0d/%0d got busy_at_done=%0b done_held=%0b want 0 0",
                 a, b, bz, st);
      end
    end
  endtask

  task automatic test_reset_mid_run;
    logic [W-1:0] q, r;
    logic z, bz, st;
    int lat;
    int done_seen;
    do_div(7, 0, q, r, z, bz, st, lat);
    bus.start = 1'b1;
    bus.in1   = W'(12);
    bus.in2   = W'(5);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL midrun_busy got=%0b want=1", bus.busy);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.out, bus.remainder, bus.busy, bus.done, bus.div_by_zero} !== '0) begin
      bad++;
      $display("FAIL midrun_reset_outputs got=%h want=0",
               {bus.out, bus.remainder, bus.busy, bus.done, bus.div_by_zero});
    end
    done_seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus.done) done_seen++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus.done) done_seen++;
    end
    total++;
    if (done_seen != 0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL midrun_no_done got done_count=%0d busy=%0b want 0 0", done_seen, bus.busy);
    end
    do_div(12, 5, q, r, z, bz, st, lat);
    total++;
    if (q !== W'(2) || r !== W'(2) || lat != LAT_FULL) begin
      bad++;
      $display("FAIL after_reset_12_5 got q=%0d r=%0d lat=%0d want q=2 r=2 lat=%0d",
               q, r, lat, LAT_FULL);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    int glitches;
    bit seen;
    logic [W-1:0] q, r;
    bus.start = 1'b1;
    bus.in1   = W'(9);
    bus.in2   = W'(3);
    lat       = 0;
    glitches  = 0;
    seen      = 1'b0;
    q         = '0;
    r         = '0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) begin
        seen = 1'b1;
        q    = bus.out;
        r    = bus.remainder;
        if (bus.busy !== 1'b0) glitches++;
        bus.start = 1'b0;
      end else begin
        if (bus.busy !== 1'b1) glitches++;
        // Competing request held through the run and the finish cycle.
        bus.start = 1'b1;
        bus.in1   = W'(14);
        bus.in2   = W'(2);
      end
    end
    total++;
    if (q !== W'(3) || r !== W'(0) || lat != LAT_FULL) begin
      bad++;
      $display("FAIL busy_ignore_result got q=%0d r=%0d lat=%0d want q=3 r=0 lat=%0d",
               q, r, lat, LAT_FULL);
    end
    total++;
    if (glitches != 0) begin
      bad++;
      $display("FAIL busy_ignore_busy got glitches=%0d want=0", glitches);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL busy_ignore_no_restart got busy=%0b done=%0b want 0 0", bus.busy, bus.done);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.in1   = '0;
    bus.in2   = '0;
    test_reset();
    test_directed();
    test_sweep_random();
    test_reset_mid_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
